// File: rtl/mmu_pkg.sv
// Shared op/error encodings for the mmu command sequencer.
package mmu_pkg;
  localparam int OP_W  = 2;
  localparam int ERR_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 2'd0,
    OP_LOAD = 2'd1,
    OP_SWAP = 2'd2,
    OP_MULT = 2'd3
  } mmu_op_t;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE      = 2'd0,
    ERR_NO_STAGED = 2'd1,
    ERR_NO_ACTIVE = 2'd2,
    ERR_TIMEOUT   = 2'd3
  } mmu_err_t;
endpackage

// File: rtl/mmu_wdog.sv
// Wait-state watchdog: counts cycles spent in the current wait state.
// Latency: expired is combinational from the count; count updates each clock.
// Backpressure: none; clear restarts the count on every state change.
module mmu_wdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The current cycle counts too: the wait state ends on its TIMEOUT_CYCLES-th cycle.
  assign expired = enable && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mmu_seq.sv
// Command sequencer for the systolic mmu: LOAD/SWAP/MULT ops to ordered one-cycle controls.
// Latency: SWAP pulse 1 cycle after accept; LOAD/MULT follow mmu handshakes.
// Backpressure: cmd_ready only when idle; result held while consumer stalls (no timeout).
module mmu_seq
  import mmu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  input  logic       weight_ld_rdy,
  output logic       weight_ld_start,
  output logic       weight_swap,
  input  logic       mult_rdy,
  output logic       mult_run,
  input  logic       acc_out_rdy,
  output logic       acc_out_pop,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       busy,
  output logic       err,
  output logic [1:0] err_code,
  input  logic       err_clr
);
  typedef enum logic [3:0] {
    S_IDLE, S_LD_WAIT, S_LD_GO, S_LD_BUSY, S_SWAP,
    S_MUL_WAIT, S_MUL_GO, S_MUL_BUSY, S_RESULT
  } state_t;

  state_t   r_state, w_next;
  logic     r_staged_v, r_active_v, r_ld_low, r_err;
  mmu_err_t r_err_code, w_err_code;
  logic     w_accept, w_err_set, w_set_staged, w_clr_staged;
  logic     w_wd_en, w_wd_clr, w_wd_exp;

  assign w_accept  = cmd_valid && cmd_ready;
  assign w_wd_en   = r_state inside {S_LD_WAIT, S_LD_BUSY, S_MUL_WAIT, S_MUL_BUSY};
  assign w_wd_clr  = (w_next != r_state);
  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;
  assign err_code  = r_err_code;

  mmu_wdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (w_wd_clr),
    .enable  (w_wd_en),
    .expired (w_wd_exp)
  );

  always_comb begin
    w_next          = r_state;
    w_err_set       = 1'b0;
    w_err_code      = ERR_NONE;
    w_set_staged    = 1'b0;
    w_clr_staged    = 1'b0;
    weight_ld_start = 1'b0;
    weight_swap     = 1'b0;
    mult_run        = 1'b0;
    res_valid       = 1'b0;
    acc_out_pop     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            OP_LOAD: w_next = S_LD_WAIT;
            OP_SWAP: begin
              if (r_staged_v) w_next = S_SWAP;
              else begin w_err_set = 1'b1; w_err_code = ERR_NO_STAGED; end
            end
            OP_MULT: begin
              if (r_active_v) w_next = S_MUL_WAIT;
              else begin w_err_set = 1'b1; w_err_code = ERR_NO_ACTIVE; end
            end
            default: ;
          endcase
        end
      end
      S_LD_WAIT: begin
        if (weight_ld_rdy) w_next = S_LD_GO;
        else if (w_wd_exp) begin
          w_next = S_IDLE; w_err_set = 1'b1; w_err_code = ERR_TIMEOUT; w_clr_staged = 1'b1;
        end
      end
      S_LD_GO: begin
        weight_ld_start = 1'b1;
        w_next          = S_LD_BUSY;
      end
      S_LD_BUSY: begin
        // Completion needs the mmu to drop ready and raise it again.
        if (r_ld_low && weight_ld_rdy) begin
          w_next = S_IDLE; w_set_staged = 1'b1;
        end else if (w_wd_exp) begin
          w_next = S_IDLE; w_err_set = 1'b1; w_err_code = ERR_TIMEOUT; w_clr_staged = 1'b1;
        end
      end
      S_SWAP: begin
        weight_swap = 1'b1;
        w_next      = S_IDLE;
      end
      S_MUL_WAIT: begin
        if (mult_rdy) w_next = S_MUL_GO;
        else if (w_wd_exp) begin
          w_next = S_IDLE; w_err_set = 1'b1; w_err_code = ERR_TIMEOUT;
        end
      end
      S_MUL_GO: begin
        mult_run = 1'b1;
        w_next   = S_MUL_BUSY;
      end
      S_MUL_BUSY: begin
        if (acc_out_rdy) w_next = S_RESULT;
        else if (w_wd_exp) begin
          w_next = S_IDLE; w_err_set = 1'b1; w_err_code = ERR_TIMEOUT;
        end
      end
      S_RESULT: begin
        res_valid   = acc_out_rdy;
        acc_out_pop = acc_out_rdy && res_ready;
        if (acc_out_pop) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_staged_v <= 1'b0;
      r_active_v <= 1'b0;
      r_ld_low   <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_state <= w_next;
      if (w_set_staged) r_staged_v <= 1'b1;
      else if (w_clr_staged || r_state == S_SWAP) r_staged_v <= 1'b0;
      if (r_state == S_SWAP) r_active_v <= 1'b1;
      if (r_state == S_LD_GO) r_ld_low <= 1'b0;
      else if (r_state == S_LD_BUSY && !weight_ld_rdy) r_ld_low <= 1'b1;
      // A new error outranks a same-cycle clear.
      if (w_err_set) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_code;
      end else if (err_clr) begin
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
      end
    end
  end
endmodule

// File: tb/tb_mmu_seq.sv
// Bench for mmu_seq: vector table, hand-written corner sequences, then random ops vs a per-op model.
module tb_mmu_seq;
  import mmu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, cmd_valid, cmd_ready, weight_ld_rdy, weight_ld_start, weight_swap;
  logic       mult_rdy, mult_run, acc_out_rdy, acc_out_pop, res_valid, res_ready;
  logic       busy, err, err_clr;
  logic [1:0] cmd_op, err_code;

  mmu_seq #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .weight_ld_rdy(weight_ld_rdy), .weight_ld_start(weight_ld_start), .weight_swap(weight_swap),
    .mult_rdy(mult_rdy), .mult_run(mult_run), .acc_out_rdy(acc_out_rdy), .acc_out_pop(acc_out_pop),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .err(err), .err_code(err_code),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int ld_t = 0, mul_t = 0, mul_stall = 0;
  bit mul_stuck = 0;
  logic s_rdy, s_st, s_sw, s_run, s_pop, s_rv, s_busy, s_err;
  logic [1:0] s_code;
  int n_st, n_sw, n_run, n_pop, sw_at;
  bit hung;

  typedef struct {
    logic [1:0] op;
    bit         clr;
    int         pulses;  // start*1000 + swap*100 + run*10 + pop
    bit         e_err;
    int         e_code;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit later, then advance the mmu mock.
  task automatic tick(input bit cv, input logic [1:0] op, input bit rr, input bit clr);
    @(negedge clk);
    cmd_valid = cv; cmd_op = op; res_ready = rr; err_clr = clr;
    weight_ld_rdy = !(ld_t >= 2 && ld_t <= 4);
    mult_rdy      = !mul_stuck && (mul_stall == 0);
    acc_out_rdy   = (mul_t >= 6);
    #1;
    s_rdy = cmd_ready; s_st = weight_ld_start; s_sw = weight_swap; s_run = mult_run;
    s_pop = acc_out_pop; s_rv = res_valid; s_busy = busy; s_err = err; s_code = err_code;
    if (weight_ld_start) ld_t = 1;
    else if (ld_t != 0) ld_t = (ld_t == 5) ? 0 : ld_t + 1;
    if (mult_run) mul_t = 1;
    else if (acc_out_pop) mul_t = 0;
    else if (mul_t != 0 && mul_t < 6) mul_t++;
    if (mul_stall != 0) mul_stall--;
  endtask

  task automatic run_cmd(input logic [1:0] op, input bit rnd_rr, input bit clr);
    n_st = 0; n_sw = 0; n_run = 0; n_pop = 0; sw_at = -1; hung = 1;
    tick(1'b1, op, rnd_rr ? 1'($urandom_range(0, 1)) : 1'b1, clr);
    n_st += s_st; n_sw += s_sw; n_run += s_run; n_pop += s_pop;
    for (int j = 1; j <= 60; j++) begin
      tick(1'b0, 2'd0, rnd_rr ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
      n_st += s_st; n_sw += s_sw; n_run += s_run; n_pop += s_pop;
      if (s_sw && sw_at < 0) sw_at = j;
      if (s_rdy) begin hung = 0; break; end
    end
  endtask

  initial begin
    int bad_cyc, ecode, e_pulses;
    bit m_staged, m_active, m_err, clr;
    int m_code;
    logic [1:0] op;

    tbl[0]  = '{OP_SWAP, 1'b0, 0,    1'b1, 1};
    tbl[1]  = '{OP_MULT, 1'b0, 0,    1'b1, 2};
    tbl[2]  = '{OP_NOP,  1'b0, 0,    1'b1, 2};
    tbl[3]  = '{OP_LOAD, 1'b0, 1000, 1'b1, 2};
    tbl[4]  = '{OP_SWAP, 1'b0, 100,  1'b1, 2};
    tbl[5]  = '{OP_MULT, 1'b0, 11,   1'b1, 2};
    tbl[6]  = '{OP_MULT, 1'b0, 11,   1'b1, 2};
    tbl[7]  = '{OP_SWAP, 1'b0, 0,    1'b1, 1};
    tbl[8]  = '{OP_LOAD, 1'b0, 1000, 1'b1, 1};
    tbl[9]  = '{OP_LOAD, 1'b0, 1000, 1'b1, 1};
    tbl[10] = '{OP_SWAP, 1'b0, 100,  1'b1, 1};
    tbl[11] = '{OP_NOP,  1'b1, 0,    1'b0, 0};
    tbl[12] = '{OP_MULT, 1'b0, 11,   1'b0, 0};
    tbl[13] = '{OP_SWAP, 1'b1, 0,    1'b1, 1};
    tbl[14] = '{OP_NOP,  1'b1, 0,    1'b0, 0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; res_ready = 1'b1; err_clr = 1'b0;
    weight_ld_rdy = 1'b1; mult_rdy = 1'b1; acc_out_rdy = 1'b0;
    repeat (3) tick(1'b0, 2'd0, 1'b1, 1'b0);
    chk("reset cmd_ready", s_rdy, 1);
    chk("reset busy", s_busy, 0);
    chk("reset err", s_err, 0);
    chk("reset err_code", s_code, 0);
    chk("reset outs", {s_st, s_sw, s_run, s_pop, s_rv}, 0);
    @(negedge clk); #2 rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      run_cmd(tbl[i].op, 1'b0, tbl[i].clr);
      chk($sformatf("vec%0d done", i), hung, 0);
      chk($sformatf("vec%0d pulses", i), n_st * 1000 + n_sw * 100 + n_run * 10 + n_pop, tbl[i].pulses);
      chk($sformatf("vec%0d err", i), s_err, tbl[i].e_err);
      chk($sformatf("vec%0d err_code", i), s_code, tbl[i].e_code);
      if (tbl[i].pulses / 100 % 10 == 1) chk($sformatf("vec%0d swap lat", i), sw_at, 1);
    end

    // Reset while the multiply is in flight; the mock keeps running and will raise acc_out_rdy.
    tick(1'b1, OP_MULT, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 2'd0, 1'b1, 1'b0);
    chk("pre-reset busy", s_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid reset busy", busy, 0);
    chk("mid reset outs", {weight_ld_start, weight_swap, mult_run, acc_out_pop, res_valid, err, err_code}, 0);
    chk("mid reset cmd_ready", cmd_ready, 1);
    @(negedge clk); #2 rst_n = 1'b1;
    bad_cyc = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1'b0, 2'd0, 1'b1, 1'b0);
      if (!s_rdy || s_busy || s_st || s_sw || s_run || s_pop || s_rv) bad_cyc++;
    end
    chk("post-reset quiet cycles", bad_cyc, 0);
    mul_t = 0;

    run_cmd(OP_SWAP, 1'b0, 1'b0);
    chk("rst swap pulses", n_sw + n_st + n_run + n_pop, 0);
    chk("rst swap code", s_code, 1);
    run_cmd(OP_MULT, 1'b0, 1'b0);
    chk("rst mult pulses", n_sw + n_st + n_run + n_pop, 0);
    chk("rst mult code", s_code, 2);

    tick(1'b0, 2'd0, 1'b1, 1'b1);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    chk("clr err", s_err, 0);
    run_cmd(OP_LOAD, 1'b0, 1'b0);
    chk("seq load", n_st * 1000 + n_sw * 100 + n_run * 10 + n_pop, 1000);
    run_cmd(OP_SWAP, 1'b0, 1'b0);
    chk("seq swap", n_st * 1000 + n_sw * 100 + n_run * 10 + n_pop, 100);
    chk("seq swap lat", sw_at, 1);
    run_cmd(OP_MULT, 1'b0, 1'b0);
    chk("seq mult", n_st * 1000 + n_sw * 100 + n_run * 10 + n_pop, 11);
    chk("seq err", s_err, 0);

    // Consumer stall longer than the watchdog limit must not time out.
    tick(1'b1, OP_MULT, 1'b0, 1'b0);
    for (int k = 0; k < 30 && !s_rv; k++) tick(1'b0, 2'd0, 1'b0, 1'b0);
    chk("stall res_valid", s_rv, 1);
    bad_cyc = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1'b0, 2'd0, 1'b0, 1'b0);
      if (!s_rv || s_pop || s_err || s_rdy) bad_cyc++;
    end
    chk("stall held cycles", bad_cyc, 0);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    chk("stall pop", s_pop, 1);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    chk("stall idle", s_rdy, 1);

    mul_stuck = 1;
    n_run = 0;
    tick(1'b1, OP_MULT, 1'b1, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      tick(1'b0, 2'd0, 1'b1, 1'b0);
      n_run += s_run;
      if (k == 8) chk("wdog not yet", {s_err, s_busy}, 1);
      if (k == 9) begin
        chk("wdog err", s_err, 1);
        chk("wdog code", s_code, 3);
        chk("wdog cmd_ready", s_rdy, 1);
      end
    end
    chk("wdog no run", n_run, 0);
    mul_stuck = 0;

    tick(1'b1, OP_SWAP, 1'b1, 1'b1);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    chk("clr+err err", s_err, 1);
    chk("clr+err code", s_code, 1);
    tick(1'b0, 2'd0, 1'b1, 1'b1);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    chk("clr alone", {s_err, s_code}, 0);

    m_staged = 0; m_active = 1; m_err = 0; m_code = 0;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 4) == 0);
      if (op == OP_MULT) mul_stall = $urandom_range(0, 3);
      e_pulses = 0; ecode = 0;
      case (op)
        OP_LOAD: begin e_pulses = 1000; m_staged = 1; end
        OP_SWAP: if (m_staged) begin e_pulses = 100; m_active = 1; m_staged = 0; end else ecode = 1;
        OP_MULT: if (m_active) e_pulses = 11; else ecode = 2;
        default: ;
      endcase
      if (ecode != 0) begin m_err = 1; m_code = ecode; end
      else if (clr) begin m_err = 0; m_code = 0; end
      run_cmd(op, 1'b1, clr);
      chk($sformatf("rnd%0d done", i), hung, 0);
      chk($sformatf("rnd%0d op%0d pulses", i, op), n_st * 1000 + n_sw * 100 + n_run * 10 + n_pop, e_pulses);
      chk($sformatf("rnd%0d err", i), s_err, m_err);
      chk($sformatf("rnd%0d err_code", i), s_code, m_code);
      if (e_pulses == 100) chk($sformatf("rnd%0d swap lat", i), sw_at, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global time limit: got no finish expected finish");
    $fatal(1, "time limit");
  end
endmodule
